arb_mux4: RTL and testbench

Round-robin arbiter and sequencer for four 32-bit requesters sharing one result channel. It selects one requester per burst, drives the select of the shared 4-way datapath selector, and registers the chosen beat into a single-entry output stage with a valid/ready handshake. It sits between the execution-side producers (ALU, multiplier/divider, load unit, CP0) and the shared writeback path.

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_mux4_if.sv | 38 +++
 rtl/mux4_32.sv | 24 ++
 rtl/rr_pick4.sv | 27 ++
 rtl/arb_mux4.sv | 156 +++++++++++++++
 tb/tb_arb_mux4.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Holds the FSM state enum, requester sizing and the beat counter width helper.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SRC_W   = 2;

    // Beat counter width; a one-beat limit still needs a one-bit counter.
    function automatic int cnt_w(input int max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/arb_mux4_if.sv
// Requester and output-channel bundle for arb_mux4.
// slave: arbiter side (takes requests, drives output beat); master: the peers.
interface arb_mux4_if
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [DATA_WIDTH-1:0] req_data0;
    logic [DATA_WIDTH-1:0] req_data1;
    logic [DATA_WIDTH-1:0] req_data2;
    logic [DATA_WIDTH-1:0] req_data3;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [SRC_W-1:0]      out_src;
    logic                  out_ready;

    modport slave (
        input  req_valid, req_last,
        input  req_data0, req_data1, req_data2, req_data3,
        input  out_ready,
        output req_ready,
        output out_valid, out_data, out_last, out_src
    );

    modport master (
        output req_valid, req_last,
        output req_data0, req_data1, req_data2, req_data3,
        output out_ready,
        input  req_ready,
        input  out_valid, out_data, out_last, out_src
    );

endinterface

// File: rtl/mux4_32.sv
// Shared 4-way datapath selector feeding the arbiter output stage.
// Ports: d0..d3 data inputs, sel select, y selected data.
module mux4_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        unique case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
// Ports: valid_i (request vector), ptr_i (start point), win_o (winner), any_o.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [SRC_W-1:0]   win_o,
    output logic               any_o
);

    logic [SRC_W-1:0] idx;

    // Walk from the lowest priority up so the highest priority hit wins.
    always_comb begin
        win_o = ptr_i;
        any_o = |valid_i;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + SRC_W'(k);
            if (valid_i[idx]) begin
                win_o = idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux4.sv
// Round-robin burst arbiter for four requesters with a one-entry output stage.
// Ports: clk, rst_n, bus (requests + output handshake), grant_sel, busy, burst_err.
module arb_mux4
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    arb_mux4_if.slave        bus,
    output logic [SRC_W-1:0] grant_sel,
    output logic             busy,
    output logic             burst_err
);

    localparam int            CW      = cnt_w(MAX_BEATS);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS - 1);

    state_t                state_q, state_d;
    logic [SRC_W-1:0]      owner_q, owner_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  ol_q, ol_d;
    logic [SRC_W-1:0]      os_q, os_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [SRC_W-1:0]      pick_ptr;
    logic [SRC_W-1:0]      pick_win;
    logic                  pick_any;
    logic                  free;
    logic                  acc;
    logic                  own_last;
    logic                  wd_end;
    logic                  burst_end;

    mux4_32 #(
        .W (DATA_WIDTH)
    ) u_sel (
        .d0  (bus.req_data0),
        .d1  (bus.req_data1),
        .d2  (bus.req_data2),
        .d3  (bus.req_data3),
        .sel (owner_q),
        .y   (sel_data)
    );

    // In LOCK the picker only matters at burst end, where the new
    // pointer is owner+1; in IDLE it searches from the stored pointer.
    assign pick_ptr = (state_q == LOCK) ? owner_q + 1'b1 : ptr_q;

    rr_pick4 u_pick (
        .valid_i (bus.req_valid),
        .ptr_i   (pick_ptr),
        .win_o   (pick_win),
        .any_o   (pick_any)
    );

    assign free      = !ov_q || bus.out_ready;
    assign acc       = (state_q == LOCK) && free && bus.req_valid[owner_q];
    assign own_last  = bus.req_last[owner_q];
    assign wd_end    = (cnt_q == CNT_MAX);
    assign burst_end = acc && (own_last || wd_end);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        os_d    = os_q;

        if (acc) begin
            ov_d  = 1'b1;
            od_d  = sel_data;
            ol_d  = own_last || wd_end;
            os_d  = owner_q;
            cnt_d = cnt_q + 1'b1;
        end else if (bus.out_ready) begin
            ov_d = 1'b0;
        end

        if (burst_end) begin
            cnt_d = '0;
            ptr_d = owner_q + 1'b1;
            if (!own_last) begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_win;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // Hand over in the same cycle so bursts run back to back.
                if (burst_end) begin
                    if (pick_any) begin
                        owner_d = pick_win;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            os_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            os_q    <= os_d;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (acc) begin
            bus.req_ready[owner_q] = 1'b1;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_last  = ol_q;
    assign bus.out_src   = os_q;
    assign grant_sel     = owner_q;
    assign busy          = (state_q == LOCK);
    assign burst_err     = err_q;

endmodule

// File: tb/tb_arb_mux4.sv
// Directed bench for arb_mux4 (MAX_BEATS=4): vector table plus corner sequences.
// Inputs change 1ns after posedge; outputs are checked on the falling edge.
module tb_arb_mux4;
    import arb_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant_sel;
    logic       busy;
    logic       burst_err;

    int total;
    int bad;

    arb_mux4_if #(.DATA_WIDTH(32)) bus ();

    arb_mux4 #(
        .DATA_WIDTH (32),
        .MAX_BEATS  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .grant_sel (grant_sel),
        .busy      (busy),
        .burst_err (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  val;
        logic [3:0]  last;
        logic        ordy;
        logic [1:0]  g;
        logic        b;
        logic [3:0]  rr;
        logic        ov;
        logic [31:0] od;
        logic        ol;
        logic [1:0]  os;
        logic        err;
    } vec_t;

    vec_t tbl[11];

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_0001;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'hC3C3_0003;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic r);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.out_ready = r;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1);
        bus.req_data0 = D0;
        bus.req_data1 = D1;
        bus.req_data2 = D2;
        bus.req_data3 = D3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all(input string t, input vec_t e);
        chk({t, ".grant"}, 32'(grant_sel), 32'(e.g));
        chk({t, ".busy"}, 32'(busy), 32'(e.b));
        chk({t, ".rready"}, 32'(bus.req_ready), 32'(e.rr));
        chk({t, ".ovalid"}, 32'(bus.out_valid), 32'(e.ov));
        chk({t, ".odata"}, bus.out_data, e.od);
        chk({t, ".olast"}, 32'(bus.out_last), 32'(e.ol));
        chk({t, ".osrc"}, 32'(bus.out_src), 32'(e.os));
        chk({t, ".err"}, 32'(burst_err), 32'(e.err));
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //           val     last    rdy g  b rr      ov od  ol os er
        tbl[0]  = '{4'b0100, 4'b0100, 1, 0, 0, 4'b0000, 0, 0,  0, 0, 0};
        tbl[1]  = '{4'b0100, 4'b0100, 1, 2, 1, 4'b0100, 0, 0,  0, 0, 0};
        tbl[2]  = '{4'b0000, 4'b0000, 1, 2, 1, 4'b0000, 1, D2, 1, 2, 0};
        tbl[3]  = '{4'b0000, 4'b0000, 1, 2, 1, 4'b0000, 0, D2, 1, 2, 0};
        tbl[4]  = '{4'b1111, 4'b1111, 1, 2, 1, 4'b0100, 0, D2, 1, 2, 0};
        tbl[5]  = '{4'b1111, 4'b1111, 1, 3, 1, 4'b1000, 1, D2, 1, 2, 0};
        tbl[6]  = '{4'b1111, 4'b1111, 1, 0, 1, 4'b0001, 1, D3, 1, 3, 0};
        tbl[7]  = '{4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 1, D0, 1, 0, 0};
        tbl[8]  = '{4'b1111, 4'b1111, 1, 2, 1, 4'b0100, 1, D1, 1, 1, 0};
        tbl[9]  = '{4'b1111, 4'b1111, 1, 3, 1, 4'b1000, 1, D2, 1, 2, 0};
        tbl[10] = '{4'b0000, 4'b0000, 1, 0, 1, 4'b0000, 1, D3, 1, 3, 0};

        // Single beat then round-robin rotation.
        do_reset;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].val, tbl[i].last, tbl[i].ordy);
            @(negedge clk);
            check_all($sformatf("v%0d", i), tbl[i]);
            nxt();
        end

        // Burst lock: requester 1 holds three beats while 0 waits.
        do_reset;
        bus.req_data1 = 32'h1000_0001;
        drive(4'b0010, 4'b0000, 1'b1);
        nxt();
        drive(4'b0011, 4'b0000, 1'b1);
        @(negedge clk);
        chk("lock.c1.grant", 32'(grant_sel), 32'd1);
        chk("lock.c1.rr", 32'(bus.req_ready), 32'b0010);
        nxt();
        bus.req_data1 = 32'h1000_0002;
        @(negedge clk);
        chk("lock.c2.rr", 32'(bus.req_ready), 32'b0010);
        chk("lock.c2.od", bus.out_data, 32'h1000_0001);
        chk("lock.c2.ol", 32'(bus.out_last), 32'd0);
        nxt();
        bus.req_data1 = 32'h1000_0003;
        drive(4'b0011, 4'b0010, 1'b1);
        @(negedge clk);
        chk("lock.c3.rr", 32'(bus.req_ready), 32'b0010);
        chk("lock.c3.od", bus.out_data, 32'h1000_0002);
        nxt();
        bus.req_data0 = 32'h2000_0000;
        drive(4'b0001, 4'b0001, 1'b1);
        @(negedge clk);
        chk("lock.c4.grant", 32'(grant_sel), 32'd0);
        chk("lock.c4.rr", 32'(bus.req_ready), 32'b0001);
        chk("lock.c4.od", bus.out_data, 32'h1000_0003);
        chk("lock.c4.ol", 32'(bus.out_last), 32'd1);
        chk("lock.c4.os", 32'(bus.out_src), 32'd1);
        nxt();
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("lock.c5.od", bus.out_data, 32'h2000_0000);
        chk("lock.c5.os", 32'(bus.out_src), 32'd0);
        nxt();

        // Backpressure mid-burst for five cycles.
        do_reset;
        bus.req_data2 = 32'h3000_0001;
        drive(4'b0100, 4'b0000, 1'b1);
        nxt();
        @(negedge clk);
        chk("bp.c1.rr", 32'(bus.req_ready), 32'b0100);
        nxt();
        bus.req_data2 = 32'h3000_0002;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 4'b0000, 1'b0);
            @(negedge clk);
            chk($sformatf("bp.h%0d.rr", i), 32'(bus.req_ready), 32'd0);
            chk($sformatf("bp.h%0d.ov", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp.h%0d.od", i), bus.out_data, 32'h3000_0001);
            nxt();
        end
        drive(4'b0100, 4'b0000, 1'b1);
        @(negedge clk);
        chk("bp.c7.rr", 32'(bus.req_ready), 32'b0100);
        chk("bp.c7.od", bus.out_data, 32'h3000_0001);
        nxt();
        bus.req_data2 = 32'h3000_0003;
        drive(4'b0100, 4'b0100, 1'b1);
        @(negedge clk);
        chk("bp.c8.od", bus.out_data, 32'h3000_0002);
        chk("bp.c8.ol", 32'(bus.out_last), 32'd0);
        nxt();
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("bp.c9.od", bus.out_data, 32'h3000_0003);
        chk("bp.c9.ol", 32'(bus.out_last), 32'd1);
        nxt();
        @(negedge clk);
        chk("bp.c10.ov", 32'(bus.out_valid), 32'd0);
        nxt();

        // Watchdog: requester 3 never flags last.
        do_reset;
        drive(4'b1000, 4'b0000, 1'b1);
        nxt();
        for (int i = 1; i <= 4; i++) begin
            bus.req_data3 = 32'h4000_0000 + 32'(i);
            drive(4'b1010, 4'b0000, 1'b1);
            @(negedge clk);
            chk($sformatf("wd.c%0d.rr", i), 32'(bus.req_ready), 32'b1000);
            if (i > 1) begin
                chk($sformatf("wd.c%0d.od", i), bus.out_data,
                    32'h4000_0000 + 32'(i - 1));
                chk($sformatf("wd.c%0d.ol", i), 32'(bus.out_last), 32'd0);
            end
            chk($sformatf("wd.c%0d.err", i), 32'(burst_err), 32'd0);
            nxt();
        end
        bus.req_data1 = 32'h5000_0001;
        drive(4'b0010, 4'b0010, 1'b1);
        @(negedge clk);
        chk("wd.c5.od", bus.out_data, 32'h4000_0004);
        chk("wd.c5.ol", 32'(bus.out_last), 32'd1);
        chk("wd.c5.os", 32'(bus.out_src), 32'd3);
        chk("wd.c5.err", 32'(burst_err), 32'd1);
        chk("wd.c5.grant", 32'(grant_sel), 32'd1);
        chk("wd.c5.rr", 32'(bus.req_ready), 32'b0010);
        nxt();
        drive(4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        chk("wd.c6.od", bus.out_data, 32'h5000_0001);
        chk("wd.c6.err", 32'(burst_err), 32'd1);
        nxt();
        @(negedge clk);
        chk("wd.c7.err", 32'(burst_err), 32'd1);
        nxt();

        // Asynchronous reset with a beat in flight.
        do_reset;
        bus.req_data1 = 32'h6000_0001;
        drive(4'b0010, 4'b0010, 1'b1);
        nxt();
        nxt();
        bus.req_data1 = 32'h6000_0002;
        drive(4'b0010, 4'b0000, 1'b1);
        @(negedge clk);
        chk("rst.pre.grant", 32'(grant_sel), 32'd1);
        chk("rst.pre.rr", 32'(bus.req_ready), 32'b0010);
        nxt();
        @(negedge clk);
        chk("rst.pre.ov", 32'(bus.out_valid), 32'd1);
        chk("rst.pre.od", bus.out_data, 32'h6000_0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.ov", 32'(bus.out_valid), 32'd0);
        chk("rst.od", bus.out_data, 32'd0);
        chk("rst.ol", 32'(bus.out_last), 32'd0);
        chk("rst.os", 32'(bus.out_src), 32'd0);
        chk("rst.grant", 32'(grant_sel), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rr", 32'(bus.req_ready), 32'd0);
        chk("rst.err", 32'(burst_err), 32'd0);
        nxt();
        rst_n = 1'b1;
        drive(4'b0110, 4'b0110, 1'b1);
        @(negedge clk);
        chk("rst.post.busy", 32'(busy), 32'd0);
        nxt();
        @(negedge clk);
        chk("rst.post.grant", 32'(grant_sel), 32'd1);
        chk("rst.post.rr", 32'(bus.req_ready), 32'b0010);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
